// File: rtl/dpwm_generator_if.sv
// Control/status bundle for the dead-time PWM generator: duty valid/ready
// handshake, enable and dead-time controls, gate drives and period status.
interface dpwm_generator_if #(
    parameter int WIDTH    = 8,
    parameter int DT_WIDTH = 4
);
    logic                enable;
    logic [WIDTH-1:0]    duty;
    logic                duty_valid;
    logic                duty_ready;
    logic [DT_WIDTH-1:0] dead_time;
    logic                pwm_h;
    logic                pwm_l;
    logic [WIDTH-1:0]    count;
    logic                period_start;

    modport master (
        output enable, duty, duty_valid, dead_time,
        input  duty_ready, pwm_h, pwm_l, count, period_start
    );

    modport slave (
        input  enable, duty, duty_valid, dead_time,
        output duty_ready, pwm_h, pwm_l, count, period_start
    );
endinterface

// File: rtl/dpwm_generator.sv
// Complementary PWM with dead time; gate drives lag the reference by 1 clock + dead time.
// Duty words are double-buffered; duty_ready stays low while a word waits for the period wrap.
module dpwm_generator #(
    parameter int WIDTH    = 8,
    parameter int DT_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    dpwm_generator_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DT_TO_H,
        S_HIGH,
        S_DT_TO_L,
        S_LOW
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    w_count_next;
    logic [WIDTH-1:0]    r_shadow;
    logic [WIDTH-1:0]    r_duty_active;
    logic                r_pending;
    logic                r_period_start;
    logic                r_pwm_h;
    logic                r_pwm_l;
    logic [DT_WIDTH-1:0] r_dt_cnt;
    logic [DT_WIDTH-1:0] w_dt_cnt_next;
    logic [DT_WIDTH-1:0] w_dt_load;
    logic                w_dt_zero;
    logic                w_ref;
    logic                w_accept;
    logic                w_transfer;

    assign w_count_next = bus.enable ? r_count + WIDTH'(1) : '0;
    assign w_ref        = (r_count < r_duty_active);
    assign w_accept     = bus.duty_valid && !r_pending;
    // Disabled modulator has no period to protect, so the shadow drains every edge.
    assign w_transfer   = !bus.enable || (r_count == CNT_MAX);
    assign w_dt_load    = bus.dead_time - DT_WIDTH'(1);
    assign w_dt_zero    = (bus.dead_time == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_count        <= w_count_next;
            r_period_start <= bus.enable && (w_count_next == '0);
        end
    end

    // When pending is clear the shadow already equals duty_active, so copying
    // unconditionally also covers the accept-and-transfer-on-one-edge case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow      <= '0;
            r_duty_active <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_duty_active <= r_shadow;
            end
            if (w_accept) begin
                r_shadow  <= bus.duty;
                r_pending <= 1'b1;
            end else if (w_transfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_dt_cnt_next = r_dt_cnt;
        if (!bus.enable) begin
            w_state_next  = S_IDLE;
            w_dt_cnt_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dt_zero) begin
                        w_state_next = w_ref ? S_HIGH : S_LOW;
                    end else begin
                        w_state_next  = w_ref ? S_DT_TO_H : S_DT_TO_L;
                        w_dt_cnt_next = w_dt_load;
                    end
                end
                S_HIGH: begin
                    if (!w_ref) begin
                        if (w_dt_zero) begin
                            w_state_next = S_LOW;
                        end else begin
                            w_state_next  = S_DT_TO_L;
                            w_dt_cnt_next = w_dt_load;
                        end
                    end
                end
                S_LOW: begin
                    if (w_ref) begin
                        if (w_dt_zero) begin
                            w_state_next = S_HIGH;
                        end else begin
                            w_state_next  = S_DT_TO_H;
                            w_dt_cnt_next = w_dt_load;
                        end
                    end
                end
                S_DT_TO_H, S_DT_TO_L: begin
                    // Exit target follows the live reference, not the state we came from.
                    if (r_dt_cnt == '0) begin
                        w_state_next = w_ref ? S_HIGH : S_LOW;
                    end else begin
                        w_dt_cnt_next = r_dt_cnt - DT_WIDTH'(1);
                    end
                end
                default: begin
                    w_state_next  = S_IDLE;
                    w_dt_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_dt_cnt <= '0;
            r_pwm_h  <= 1'b0;
            r_pwm_l  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_dt_cnt <= w_dt_cnt_next;
            r_pwm_h  <= (w_state_next == S_HIGH);
            r_pwm_l  <= (w_state_next == S_LOW);
        end
    end

    assign bus.duty_ready   = !r_pending;
    assign bus.pwm_h        = r_pwm_h;
    assign bus.pwm_l        = r_pwm_l;
    assign bus.count        = r_count;
    assign bus.period_start = r_period_start;
endmodule

// File: tb/tb_dpwm_generator.sv
// Directed bench for dpwm_generator at WIDTH=4: steady-state timing, double-buffered
// duty updates, duty extremes, zero dead time, enable drop and asynchronous reset.
module tb_dpwm_generator;
    logic clk = 1'b0;
    logic rst = 1'b1;

    dpwm_generator_if #(.WIDTH(4), .DT_WIDTH(4)) bus ();

    dpwm_generator #(.WIDTH(4), .DT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d (bench count %0d)", tag, obs, exp, exp_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst || !bus.enable) exp_cnt = 0;
        else exp_cnt = (exp_cnt + 1) % 16;
        #1;
    endtask

    task automatic chk_cycle(input string tag, input logic eh, input logic el, input logic eps);
        chk({tag, "_count"}, bus.count, exp_cnt);
        chk({tag, "_pwm_h"}, bus.pwm_h, eh);
        chk({tag, "_pwm_l"}, bus.pwm_l, el);
        chk({tag, "_period_start"}, bus.period_start, eps);
        chk({tag, "_overlap"}, bus.pwm_h & bus.pwm_l, 0);
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.duty       = '0;
        bus.duty_valid = 1'b0;
        bus.dead_time  = '0;
        repeat (2) tick();

        chk("rst_count", bus.count, 0);
        chk("rst_pwm_h", bus.pwm_h, 0);
        chk("rst_pwm_l", bus.pwm_l, 0);
        chk("rst_period_start", bus.period_start, 0);
        chk("rst_duty_ready", bus.duty_ready, 1);

        // Scenario 1: duty 8, dead time 2
        rst            = 1'b0;
        bus.enable     = 1'b1;
        bus.dead_time  = 4'd2;
        bus.duty       = 4'd8;
        bus.duty_valid = 1'b1;
        tick();
        bus.duty_valid = 1'b0;
        chk("s1_ready_low", bus.duty_ready, 0);
        chk("s1_count1", bus.count, 1);
        repeat (15) tick();
        chk("s1_ready_back", bus.duty_ready, 1);
        for (int i = 0; i < 32; i++) begin
            chk_cycle("s1", exp_cnt >= 3 && exp_cnt <= 8, exp_cnt >= 11 || exp_cnt == 0, exp_cnt == 0);
            tick();
        end

        // Scenario 2: duty 12 offered mid-period
        repeat (5) tick();
        chk("s2_at5", bus.count, 5);
        bus.duty       = 4'd12;
        bus.duty_valid = 1'b1;
        tick();
        bus.duty_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("s2_ready_low", bus.duty_ready, 0);
            chk_cycle("s2_old", exp_cnt <= 8, exp_cnt >= 11, 0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            chk("s2_ready_high", bus.duty_ready, 1);
            chk_cycle("s2_new", exp_cnt >= 3 && exp_cnt <= 12, exp_cnt == 15 || exp_cnt == 0, exp_cnt == 0);
            tick();
        end

        // Scenario 3: duty extremes with zero dead time
        bus.dead_time  = 4'd0;
        bus.duty       = 4'd0;
        bus.duty_valid = 1'b1;
        tick();
        bus.duty_valid = 1'b0;
        repeat (31) tick();
        for (int i = 0; i < 16; i++) begin
            chk_cycle("s3_zero", 0, 1, exp_cnt == 0);
            tick();
        end
        bus.duty       = 4'd15;
        bus.duty_valid = 1'b1;
        tick();
        bus.duty_valid = 1'b0;
        repeat (15) tick();
        for (int i = 0; i < 16; i++) begin
            chk_cycle("s3_full", exp_cnt != 0, exp_cnt == 0, exp_cnt == 0);
            tick();
        end

        // Scenario 4: duty 4, zero dead time
        bus.duty       = 4'd4;
        bus.duty_valid = 1'b1;
        tick();
        bus.duty_valid = 1'b0;
        repeat (15) tick();
        for (int i = 0; i < 16; i++) begin
            chk_cycle("s4", exp_cnt >= 1 && exp_cnt <= 4, !(exp_cnt >= 1 && exp_cnt <= 4), exp_cnt == 0);
            chk("s4_no_gap", bus.pwm_h | bus.pwm_l, 1);
            tick();
        end

        // Scenario 5a: enable dropped while HIGH, restart with dead time 3
        repeat (2) tick();
        chk("s5_high", bus.pwm_h, 1);
        bus.enable    = 1'b0;
        bus.dead_time = 4'd3;
        #1;
        chk("s5_hold_before_edge", bus.pwm_h, 1);
        tick();
        chk_cycle("s5_disabled", 0, 0, 0);
        tick();
        chk("s5_count_held", bus.count, 0);
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_cycle("s5_restart", exp_cnt == 4, 0, 0);
        end
        repeat (12) tick();
        chk("s5_low_at_wrap", bus.pwm_l, 1);
        tick();
        chk_cycle("s5_in_dt_to_h", 0, 0, 0);

        // Scenario 5b: asynchronous reset during DT_TO_H
        rst = 1'b1;
        #2;
        exp_cnt = 0;
        chk("s5_arst_count", bus.count, 0);
        chk("s5_arst_pwm_h", bus.pwm_h, 0);
        chk("s5_arst_pwm_l", bus.pwm_l, 0);
        chk("s5_arst_period_start", bus.period_start, 0);
        chk("s5_arst_duty_ready", bus.duty_ready, 1);
        tick();
        chk("s5_arst_hold", bus.count, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_cycle("s5_rst_restart", 0, exp_cnt == 4, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
